// File: rtl/clk_freq_monitor.sv
// Clock health monitor: counts synchronized tog_i transitions over a fixed clk_sys gate
// window, range-checks each completed count and flags a stalled monitored clock.
module clk_freq_monitor #(
    parameter int G_GATE_CYCLES = 1000,
    parameter int G_CNT_WIDTH   = 32,
    parameter int G_SYNC_STAGES = 2,
    parameter int G_LOSS_CYCLES = 64
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_i,
    input  logic                   tog_i,
    input  logic                   en_i,
    input  logic [G_CNT_WIDTH-1:0] min_i,
    input  logic [G_CNT_WIDTH-1:0] max_i,
    output logic [G_CNT_WIDTH-1:0] freq_o,
    output logic                   freq_valid_o,
    output logic                   in_range_o,
    output logic                   clk_lost_o,
    output logic [15:0]            win_cnt_o
);
    localparam int GATE_W = (G_GATE_CYCLES > 1) ? $clog2(G_GATE_CYCLES) : 1;
    localparam int IDLE_W = $clog2(G_LOSS_CYCLES + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(G_GATE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] LOSS_LIM  = IDLE_W'(G_LOSS_CYCLES);

    typedef enum logic {ST_IDLE, ST_MEASURE} state_t;

    state_t                   state_q, state_d;
    logic [G_SYNC_STAGES-1:0] sync_q;
    logic                     tog_dly_q;
    logic [GATE_W-1:0]        gate_q, gate_d;
    logic [G_CNT_WIDTH-1:0]   edge_cnt_q, edge_cnt_d;
    logic [IDLE_W-1:0]        idle_q, idle_d;
    logic [G_CNT_WIDTH-1:0]   freq_q, freq_d;
    logic                     valid_q, valid_d;
    logic                     in_range_q, in_range_d;
    logic                     lost_q, lost_d;
    logic [15:0]              win_q, win_d;
    logic                     edge_w;
    logic [G_CNT_WIDTH-1:0]   edge_sum;
    logic [IDLE_W-1:0]        idle_inc;

    // The synchronizer keeps running in IDLE so re-enabling sees a settled level.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            tog_dly_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[G_SYNC_STAGES-2:0], tog_i};
            tog_dly_q <= sync_q[G_SYNC_STAGES-1];
        end
    end

    assign edge_w = sync_q[G_SYNC_STAGES-1] ^ tog_dly_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            idle_q     <= '0;
            freq_q     <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            lost_q     <= 1'b0;
            win_q      <= '0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            edge_cnt_q <= edge_cnt_d;
            idle_q     <= idle_d;
            freq_q     <= freq_d;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            lost_q     <= lost_d;
            win_q      <= win_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        edge_cnt_d = edge_cnt_q;
        idle_d     = idle_q;
        freq_d     = freq_q;
        valid_d    = 1'b0;
        in_range_d = in_range_q;
        lost_d     = 1'b0;
        win_d      = win_q;
        edge_sum   = (edge_w && (edge_cnt_q != '1)) ? edge_cnt_q + G_CNT_WIDTH'(1) : edge_cnt_q;
        idle_inc   = (idle_q != '1) ? idle_q + IDLE_W'(1) : idle_q;

        case (state_q)
            ST_IDLE: begin
                gate_d     = '0;
                edge_cnt_d = '0;
                idle_d     = '0;
                if (en_i) begin
                    state_d = ST_MEASURE;
                    win_d   = '0;
                end
            end
            ST_MEASURE: begin
                if (!en_i) begin
                    state_d    = ST_IDLE;
                    gate_d     = '0;
                    edge_cnt_d = '0;
                    idle_d     = '0;
                end else begin
                    idle_d = edge_w ? '0 : idle_inc;
                    lost_d = (idle_d >= LOSS_LIM);
                    // The edge of the terminal cycle belongs to the closing window.
                    if (gate_q == GATE_LAST) begin
                        gate_d     = '0;
                        edge_cnt_d = '0;
                        freq_d     = edge_sum;
                        valid_d    = 1'b1;
                        in_range_d = (edge_sum >= min_i) && (edge_sum <= max_i);
                        win_d      = win_q + 16'd1;
                    end else begin
                        gate_d     = gate_q + GATE_W'(1);
                        edge_cnt_d = edge_sum;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign freq_o       = freq_q;
    assign freq_valid_o = valid_q;
    assign in_range_o   = in_range_q;
    assign clk_lost_o   = lost_q;
    assign win_cnt_o    = win_q;
endmodule

// File: tb/tb_clk_freq_monitor.sv
// Self-checking bench for clk_freq_monitor: directed scenarios plus random toggle rates,
// every cycle compared against a window-level reference model built from the toggle history.
module tb_clk_freq_monitor;
    localparam int GATE = 100;
    localparam int SYNC = 2;
    localparam int LOSS = 64;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          rst, tog, en;
    logic [CW-1:0] lo, hi;
    logic [CW-1:0] freq_o;
    logic          freq_valid_o, in_range_o, clk_lost_o;
    logic [15:0]   win_cnt_o;

    clk_freq_monitor #(
        .G_GATE_CYCLES(GATE), .G_CNT_WIDTH(CW), .G_SYNC_STAGES(SYNC), .G_LOSS_CYCLES(LOSS)
    ) dut (
        .clk_sys_i(clk), .rst_i(rst), .tog_i(tog), .en_i(en), .min_i(lo), .max_i(hi),
        .freq_o(freq_o), .freq_valid_o(freq_valid_o), .in_range_o(in_range_o),
        .clk_lost_o(clk_lost_o), .win_cnt_o(win_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit hist [0:19999];

    // Reference model state: what the outputs should read during the current cycle.
    bit          m_meas  = 1'b0;
    int          m_start = 0;
    int          m_ref   = 0;
    logic [31:0] m_freq  = '0;
    bit          m_valid = 1'b0;
    bit          m_inr   = 1'b0;
    bit          m_lost  = 1'b0;
    logic [15:0] m_win   = '0;

    int tog_period = 0;
    int tog_ph     = 0;
    int last_flip  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // A tog_i change made in cycle c is seen by the counters as an edge in cycle c+SYNC.
    function automatic bit edge_at(input int c);
        if (c < SYNC + 1) return 1'b0;
        return hist[c-SYNC] != hist[c-SYNC-1];
    endfunction

    task automatic tick();
        int n;
        int c;
        c = cyc;
        hist[c] = tog;
        @(posedge clk);
        if (rst) begin
            m_meas = 0; m_freq = '0; m_valid = 0; m_inr = 0; m_lost = 0; m_win = '0;
        end else if (!m_meas) begin
            m_valid = 0;
            m_lost  = 0;
            if (en) begin
                m_meas = 1; m_start = c + 1; m_ref = c + 1; m_win = '0;
            end
        end else if (!en) begin
            m_meas = 0; m_valid = 0; m_lost = 0;
        end else begin
            m_valid = 0;
            if (edge_at(c)) m_ref = c + 1;
            if (c - m_start == GATE - 1) begin
                n = 0;
                for (int j = m_start; j <= c; j++) if (edge_at(j)) n++;
                m_freq  = n;
                m_valid = 1;
                m_inr   = (lo <= m_freq) && (m_freq <= hi);
                m_win   = m_win + 16'd1;
                m_start = c + 1;
            end
            m_lost = (c + 1 - m_ref) >= LOSS;
        end
        cyc++;
        #1;
        check("freq", freq_o, m_freq);
        check("valid", {31'd0, freq_valid_o}, {31'd0, m_valid});
        check("in_range", {31'd0, in_range_o}, {31'd0, m_inr});
        check("clk_lost", {31'd0, clk_lost_o}, {31'd0, m_lost});
        check("win_cnt", {16'd0, win_cnt_o}, {16'd0, m_win});
    endtask

    task automatic step();
        if (tog_period > 0) begin
            if (tog_ph == 0) begin
                tog = ~tog;
                last_flip = cyc;
            end
            tog_ph = (tog_ph + 1) % tog_period;
        end
        tick();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        step();
        while (freq_valid_o !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        check({tag, "_timeout"}, {31'd0, freq_valid_o}, 32'd1);
    endtask

    task automatic wait_lost(input string tag, input logic level);
        int k = 0;
        while (clk_lost_o !== level && k < 300) begin
            step();
            k++;
        end
        check({tag, "_timeout"}, {31'd0, clk_lost_o}, {31'd0, level});
    endtask

    initial begin
        int t_a;
        int f;
        int pulses;
        rst = 1'b1; en = 1'b0; tog = 1'b0; lo = '0; hi = '0;

        // Reset state
        run(3);
        check("rst_freq", freq_o, 32'd0);
        check("rst_win", {16'd0, win_cnt_o}, 32'd0);
        rst = 1'b0;
        run(2);

        // 1: tog every 4 cycles -> 25 per window, one pulse every GATE cycles
        lo = 24; hi = 26; tog_period = 4; tog_ph = 0; en = 1'b1;
        wait_valid("t1_w1");
        wait_valid("t1_w2");
        t_a = cyc;
        check("t1_freq2", freq_o, 32'd25);
        check("t1_win2", {16'd0, win_cnt_o}, 32'd2);
        check("t1_inr2", {31'd0, in_range_o}, 32'd1);
        wait_valid("t1_w3");
        check("t1_period", cyc - t_a, GATE);
        check("t1_win3", {16'd0, win_cnt_o}, 32'd3);

        // 2: range bounds sampled at update, inverted bounds never in range
        run(30);
        hi = 20;
        wait_valid("t2_w1");
        check("t2_freq", freq_o, 32'd25);
        check("t2_inr_lo", {31'd0, in_range_o}, 32'd0);
        lo = 30; hi = 20;
        wait_valid("t2_w2");
        check("t2_inr_inv", {31'd0, in_range_o}, 32'd0);
        lo = 25; hi = 25;
        wait_valid("t2_w3");
        check("t2_inr_eq", {31'd0, in_range_o}, 32'd1);

        // 3: toggle every cycle, then stop and resume
        tog_period = 1; tog_ph = 0;
        wait_valid("t3_w1");
        wait_valid("t3_w2");
        check("t3_freq_max", freq_o, GATE);
        tog_period = 0;
        wait_lost("t3_lost_set", 1'b1);
        check("t3_lost_delay", cyc - last_flip, SYNC + 1 + LOSS);
        tog_period = 4; tog_ph = 0;
        step();
        f = last_flip;
        wait_lost("t3_lost_clr", 1'b0);
        check("t3_clr_delay", cyc - f, SYNC + 1);

        // 4: drop enable mid-window, then re-enable
        wait_valid("t4_w1");
        wait_valid("t4_w2");
        check("t4_freq_pre", freq_o, 32'd25);
        run(50);
        en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (freq_valid_o === 1'b1) pulses++;
        end
        check("t4_no_pulse", pulses, 32'd0);
        check("t4_freq_hold", freq_o, 32'd25);
        check("t4_lost_idle", {31'd0, clk_lost_o}, 32'd0);
        en = 1'b1;
        step();
        step();
        check("t4_win_zero", {16'd0, win_cnt_o}, 32'd0);
        wait_valid("t4_w3");
        check("t4_win_one", {16'd0, win_cnt_o}, 32'd1);

        // 5: reset mid-window while clock is flagged lost
        tog_period = 0;
        if (tog) tog = 1'b0;
        wait_lost("t5_lost", 1'b1);
        rst = 1'b1;
        step();
        check("t5_freq", freq_o, 32'd0);
        check("t5_valid", {31'd0, freq_valid_o}, 32'd0);
        check("t5_inr", {31'd0, in_range_o}, 32'd0);
        check("t5_lost", {31'd0, clk_lost_o}, 32'd0);
        check("t5_win", {16'd0, win_cnt_o}, 32'd0);
        rst = 1'b0;
        tog_period = 4; tog_ph = 0;
        wait_valid("t5_w1");
        wait_valid("t5_w2");
        check("t5_freq2", freq_o, 32'd25);
        check("t5_win2", {16'd0, win_cnt_o}, 32'd2);

        // 6: single edge landing on the last gate cycle
        tog_period = 0;
        wait_valid("t6_w1");
        wait_valid("t6_w2");
        wait_valid("t6_w3");
        check("t6_quiet", freq_o, 32'd0);
        run(GATE - 1 - SYNC);
        tog = ~tog;
        wait_valid("t6_w4");
        check("t6_last_edge", freq_o, 32'd1);
        wait_valid("t6_w5");
        check("t6_next_zero", freq_o, 32'd0);

        // Random toggle rates, bounds and enable drops
        for (int it = 0; it < 8; it++) begin
            tog_period = $urandom_range(1, 9);
            tog_ph = 0;
            lo = $urandom_range(0, 60);
            hi = $urandom_range(0, 60);
            run($urandom_range(50, 250));
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                run($urandom_range(1, 20));
                en = 1'b1;
            end
        end
        run(GATE + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clk_freq_monitor.md
Name: clk_freq_monitor

Overview:
Receive-side counterpart of the bench clock/reset generator. It measures the frequency of a monitored clock against clk_sys, flags out-of-range values and flags loss of clock. The monitored clock domain drives a divide-by-2 toggle signal into tog_i, asynchronously to clk_sys. The block synchronizes tog_i, counts its transitions over a fixed gate window and reports the count once per window. It is used in the FMC/ADC testbenches and in-system as a clock health monitor.

Parameters:
G_GATE_CYCLES, 1000, clk_sys cycles per measurement window (>=2).
G_CNT_WIDTH, 32, width of the frequency count and thresholds.
G_SYNC_STAGES, 2, synchronizer flip-flops on tog_i (>=2).
G_LOSS_CYCLES, 64, consecutive edge-free clk_sys cycles that declare clock loss.

Ports:
clk_sys_i  in  1  system clock; sole clock of the block.
rst_i  in  1  synchronous active-high reset.
tog_i  in  1  async toggle; flips once per monitored-clock rising edge.
en_i  in  1  measurement enable (level).
min_i  in  G_CNT_WIDTH  lower in-range bound, inclusive.
max_i  in  G_CNT_WIDTH  upper in-range bound, inclusive.
freq_o  out  G_CNT_WIDTH  transitions counted in the last completed window.
freq_valid_o  out  1  one-cycle pulse when freq_o updates.
in_range_o  out  1  min_i <= freq_o <= max_i, evaluated at update.
clk_lost_o  out  1  no tog_i transition for G_LOSS_CYCLES cycles.
win_cnt_o  out  16  completed windows since enable; wraps 0xFFFF->0.

Behaviour:
- Reset (rst_i=1 at a clk_sys_i edge): all outputs 0, synchronizer cleared, FSM to IDLE. Reset overrides everything, including mid-window; any partial count is discarded.
- Sync/edge detection:
  - tog_i passes through G_SYNC_STAGES FFs.
  - edge = XOR of the last sync stage and one further delayed stage.
  - Latency from a tog_i change to the edge pulse is G_SYNC_STAGES+1 cycles.
  - Transitions faster than one per clk_sys cycle are out of spec; the count is then undefined but no lock-up is allowed.
- FSM IDLE:
  - gate_cnt=0, edge_cnt=0, clk_lost_o=0.
  - freq_o, in_range_o and win_cnt_o hold their values.
  - en_i=1 -> MEASURE next cycle, win_cnt_o cleared.
- FSM MEASURE:
  - gate_cnt increments every cycle, from 0 to G_GATE_CYCLES-1.
  - edge_cnt increments on each edge and saturates at all-ones (no wrap).
  - When gate_cnt=G_GATE_CYCLES-1:
    - freq_o <= edge_cnt + edge of this cycle (saturating).
    - freq_valid_o=1 for exactly the next cycle.
    - in_range_o is computed from the new value in the same register update, with min_i/max_i sampled in that cycle.
    - win_cnt_o increments.
    - gate_cnt and edge_cnt restart at 0; no edge is lost or double-counted across windows.
  - The first window after enable is reported normally. It may under-count by up to the sync latency.
- en_i deasserted in MEASURE -> IDLE next cycle. The partial window is discarded; no valid pulse is issued.
- Loss detector (MEASURE only):
  - idle_cnt counts cycles since the last edge and is cleared on each edge.
  - Reaching G_LOSS_CYCLES sets clk_lost_o.
  - The first subsequent edge clears clk_lost_o in the cycle after that edge.
  - idle_cnt saturates and does not wrap.
  - Leaving MEASURE clears clk_lost_o.
- If min_i > max_i, in_range_o=0 always.

Test Plan:
1. G_GATE_CYCLES=100, tog_i flips every 4 clk_sys cycles, en_i=1 -> every window after the first gives freq_o=25, freq_valid_o pulses every 100 cycles, win_cnt_o=1,2,3...
2. Same stimulus, min_i=24, max_i=26 -> in_range_o=1. Then max_i=20 before the next window ends -> in_range_o=0 at the next update, freq_o still 25.
3. tog_i flips every cycle -> freq_o=100 (=G_GATE_CYCLES). Stop toggling -> clk_lost_o=1 exactly 64 cycles after the last detected edge. Resume toggling -> clk_lost_o=0 one cycle after the first new edge.
4. Drop en_i at gate_cnt=50 -> no freq_valid_o pulse, freq_o holds its last value, clk_lost_o=0. Re-enable -> win_cnt_o restarts from 0, then 1 after 100 cycles.
5. Assert rst_i mid-window with clk_lost_o=1 -> the next cycle shows every output at 0. After release with en_i=1, the first window reports correctly.
6. An edge in the last gate cycle of a window is counted in that window: tog_i flip timed so its edge lands on gate_cnt=99 -> freq_o includes it and the next window starts from edge_cnt=0.
